// File: rtl/rv_hazard_scoreboard.sv
// Hazard unit for the pipelined RISC-V core. It provides forwarding selects, load-use, multi-cycle and
// no-forwarding stalls, a memory-ready freeze, and a scoreboard for one fixed-latency multi-cycle unit.
module rv_hazard_scoreboard #(
  parameter int REGW   = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] Rs1D,
  input  logic [REGW-1:0] Rs2D,
  input  logic [REGW-1:0] RdD,
  input  logic            RegWriteD,
  input  logic [REGW-1:0] Rs1E,
  input  logic [REGW-1:0] Rs2E,
  input  logic [REGW-1:0] RdE,
  input  logic            RegWriteE,
  input  logic            ResultSrcb0E,
  input  logic            McStartE,
  input  logic            PCSrcE,
  input  logic [REGW-1:0] RdM,
  input  logic [REGW-1:0] RdW,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemReadyM,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic            StallF,
  output logic            StallD,
  output logic            StallE,
  output logic            StallM,
  output logic            FlushD,
  output logic            FlushE,
  output logic            BubbleM,
  output logic            McWbValid,
  output logic            McRd_unused_guard,
  output logic [REGW-1:0] McRd,
  output logic            McBusy
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MC_LAT - 1);

  logic            out_en;
  logic            busy;
  logic [CW-1:0]   cnt;
  logic [REGW-1:0] mc_rd;

  logic freeze, wb_raw, retire, issue;
  logic ld_stall, mc_raw, mc_waw, mc_struct, nf_stall, d_stall;

  function automatic logic hit(input logic [REGW-1:0] dst, input logic [REGW-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src, input logic wb,
                                         input logic [REGW-1:0] rd_m, input logic we_m,
                                         input logic [REGW-1:0] rd_w, input logic we_w,
                                         input logic [REGW-1:0] rd_mc);
    if (we_m && hit(rd_m, src))     return 2'b10;
    else if (we_w && hit(rd_w, src)) return 2'b01;
    else if (wb && hit(rd_mc, src))  return 2'b11;
    else                             return 2'b00;
  endfunction

  assign freeze = !MemReadyM;
  // A pipe write in W owns the regfile port; the MC result waits with its counter parked at zero.
  assign wb_raw = busy && (cnt == '0) && !RegWriteW;
  assign retire = wb_raw && !freeze;
  assign issue  = McStartE && (!busy || wb_raw) && !freeze;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_en <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      mc_rd  <= '0;
    end else begin
      out_en <= 1'b1;
      if (out_en) begin
        if (busy && (cnt != '0)) cnt <= cnt - CW'(1);
        if (retire) busy <= 1'b0;
        if (issue) begin
          busy  <= 1'b1;
          mc_rd <= RdE;
          cnt   <= CNT_INIT;
        end
      end
    end
  end

  always_comb begin
    ld_stall  = ResultSrcb0E && (hit(RdE, Rs1D) || hit(RdE, Rs2D));
    mc_raw    = busy && (hit(mc_rd, Rs1D) || hit(mc_rd, Rs2D)) && !wb_raw;
    mc_waw    = busy && RegWriteD && hit(mc_rd, RdD);
    mc_struct = McStartE && busy && !wb_raw;
    nf_stall  = 1'b0;
    if (FWD_EN == 0)
      nf_stall = (RegWriteE && (hit(RdE, Rs1D) || hit(RdE, Rs2D))) ||
                 (RegWriteM && (hit(RdM, Rs1D) || hit(RdM, Rs2D))) ||
                 (RegWriteW && (hit(RdW, Rs1D) || hit(RdW, Rs2D)));
    d_stall   = ld_stall || mc_raw || mc_waw || nf_stall;
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    BubbleM   = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    McWbValid = 1'b0;
    McBusy    = 1'b0;
    McRd      = '0;
    if (out_en) begin
      // A taken branch held in a frozen E stage flushes once memory is ready again.
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (mc_struct) begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        BubbleM = 1'b1;
      end else begin
        StallF = d_stall;
        StallD = d_stall;
        FlushE = d_stall || PCSrcE;
        FlushD = PCSrcE;
      end
      if (FWD_EN != 0) begin
        ForwardAE = fwd_sel(Rs1E, wb_raw, RdM, RegWriteM, RdW, RegWriteW, mc_rd);
        ForwardBE = fwd_sel(Rs2E, wb_raw, RdM, RegWriteM, RdW, RegWriteW, mc_rd);
      end
      McWbValid = wb_raw;
      McBusy    = busy;
      McRd      = mc_rd;
    end
  end

  assign McRd_unused_guard = 1'b0;

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// Randomised bench for rv_hazard_scoreboard: forwarding and stall-only builds are driven side by side
// and compared each cycle against a time-stamped scoreboard model.
module tb_rv_hazard_scoreboard;
  localparam int REGW   = 5;
  localparam int MC_LAT = 4;

  logic clk = 1'b0;
  logic reset;
  logic [REGW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteD, RegWriteE, ResultSrcb0E, McStartE, PCSrcE, RegWriteM, RegWriteW, MemReadyM;

  logic [1:0] fa_f, fb_f, fa_n, fb_n;
  logic sf_f, sd_f, se_f, sm_f, fd_f, fe_f, bm_f, wb_f, g_f, busy_f;
  logic sf_n, sd_n, se_n, sm_n, fd_n, fe_n, bm_n, wb_n, g_n, busy_n;
  logic [REGW-1:0] rd_f, rd_n;

  always #5 clk = ~clk;

  rv_hazard_scoreboard #(.REGW(REGW), .MC_LAT(MC_LAT), .FWD_EN(1)) dut_f (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcb0E(ResultSrcb0E),
    .McStartE(McStartE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReadyM(MemReadyM), .ForwardAE(fa_f), .ForwardBE(fb_f),
    .StallF(sf_f), .StallD(sd_f), .StallE(se_f), .StallM(sm_f), .FlushD(fd_f), .FlushE(fe_f),
    .BubbleM(bm_f), .McWbValid(wb_f), .McRd_unused_guard(g_f), .McRd(rd_f), .McBusy(busy_f));

  rv_hazard_scoreboard #(.REGW(REGW), .MC_LAT(MC_LAT), .FWD_EN(0)) dut_n (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcb0E(ResultSrcb0E),
    .McStartE(McStartE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReadyM(MemReadyM), .ForwardAE(fa_n), .ForwardBE(fb_n),
    .StallF(sf_n), .StallD(sd_n), .StallE(se_n), .StallM(sm_n), .FlushD(fd_n), .FlushE(fe_n),
    .BubbleM(bm_n), .McWbValid(wb_n), .McRd_unused_guard(g_n), .McRd(rd_n), .McBusy(busy_n));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // The model tracks the pending MC result by the cycle number at which it becomes valid.
  bit              m_en, m_pend, m_wbv;
  logic [REGW-1:0] m_dst;
  int              m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit hit(input logic [REGW-1:0] dst, input logic [REGW-1:0] src);
    return (dst != 0) && (dst == src);
  endfunction

  function automatic logic [1:0] fsel(input logic [REGW-1:0] s);
    if (RegWriteM && hit(RdM, s)) return 2'b10;
    if (RegWriteW && hit(RdW, s)) return 2'b01;
    if (m_wbv && hit(m_dst, s))   return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [REGW-1:0] rnd_reg();
    return REGW'($urandom_range(0, 7));
  endfunction

  task automatic drive_random();
    Rs1D = rnd_reg(); Rs2D = rnd_reg(); RdD = rnd_reg();
    Rs1E = rnd_reg(); Rs2E = rnd_reg(); RdE = rnd_reg();
    RdM  = rnd_reg(); RdW  = rnd_reg();
    RegWriteD    = ($urandom_range(0, 1) == 1);
    RegWriteE    = ($urandom_range(0, 1) == 1);
    RegWriteM    = ($urandom_range(0, 1) == 1);
    RegWriteW    = ($urandom_range(0, 1) == 1);
    ResultSrcb0E = ($urandom_range(0, 3) == 0);
    McStartE     = ($urandom_range(0, 3) == 0);
    PCSrcE       = ($urandom_range(0, 7) == 0);
    MemReadyM    = ($urandom_range(0, 4) != 0);
  endtask

  task automatic check_outputs();
    bit ld, mraw, mwaw, mst, nf, ds;
    logic [3:0] st;
    logic [2:0] fl;
    logic [3:0] fw;
    logic [REGW+1:0] mc;
    m_wbv = m_en && m_pend && (cyc >= m_ready) && !RegWriteW;
    ld   = ResultSrcb0E && (hit(RdE, Rs1D) || hit(RdE, Rs2D));
    mraw = m_pend && (hit(m_dst, Rs1D) || hit(m_dst, Rs2D)) && !m_wbv;
    mwaw = m_pend && RegWriteD && hit(m_dst, RdD);
    mst  = McStartE && m_pend && !m_wbv;
    nf   = (RegWriteE && (hit(RdE, Rs1D) || hit(RdE, Rs2D))) ||
           (RegWriteM && (hit(RdM, Rs1D) || hit(RdM, Rs2D))) ||
           (RegWriteW && (hit(RdW, Rs1D) || hit(RdW, Rs2D)));
    mc = {m_wbv, m_en && m_pend, m_en ? m_dst : REGW'(0)};
    for (int fwd = 0; fwd < 2; fwd++) begin
      ds = ld || mraw || mwaw || (fwd == 0 && nf);
      if (!MemReadyM)  begin st = 4'b1111; fl = 3'b000; end
      else if (mst)    begin st = 4'b1110; fl = 3'b001; end
      else             begin st = {ds, ds, 2'b00}; fl = {PCSrcE, ds || PCSrcE, 1'b0}; end
      fw = (fwd == 1) ? {fsel(Rs1E), fsel(Rs2E)} : 4'b0000;
      if (!m_en) begin st = 0; fl = 0; fw = 0; end
      if (fwd == 1) begin
        check("fwd1_forward", {fa_f, fb_f}, fw);
        check("fwd1_stall", {sf_f, sd_f, se_f, sm_f}, st);
        check("fwd1_flush", {fd_f, fe_f, bm_f}, fl);
        check("fwd1_mc", {wb_f, busy_f, rd_f}, mc);
      end else begin
        check("fwd0_forward", {fa_n, fb_n}, fw);
        check("fwd0_stall", {sf_n, sd_n, se_n, sm_n}, st);
        check("fwd0_flush", {fd_n, fe_n, bm_n}, fl);
        check("fwd0_mc", {wb_n, busy_n, rd_n}, mc);
      end
    end
  endtask

  task automatic model_step();
    bit retire, issue;
    if (!reset) return;
    if (m_en) begin
      retire = m_wbv && MemReadyM;
      issue  = McStartE && (!m_pend || m_wbv) && MemReadyM;
      if (retire) m_pend = 1'b0;
      if (issue) begin
        m_pend  = 1'b1;
        m_dst   = RdE;
        m_ready = cyc + MC_LAT;
      end
    end
    m_en = 1'b1;
    cyc++;
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_pend = 1'b0; m_dst = '0; m_ready = 0;
  endtask

  initial begin
    int rst_hold;
    bit did_mid_rst;
    reset = 1'b0;
    model_reset();
    drive_random();
    rst_hold = 0;
    did_mid_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      drive_random();
      #1 check_outputs();
      @(posedge clk);
      model_step();
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive_random();
      if (i > 1500 && !did_mid_rst && m_pend && (cyc < m_ready)) begin
        did_mid_rst = 1'b1;
        rst_hold = 2;
      end
      if (rst_hold > 0) begin
        reset = 1'b0;
        rst_hold--;
        model_reset();
        #1 check("midrst_busy", {busy_f, busy_n, wb_f, wb_n}, 4'b0000);
      end else begin
        reset = 1'b1;
        #1;
      end
      check_outputs();
      @(posedge clk);
      model_step();
    end
    if (!did_mid_rst) check("midrst_reached", 32'(did_mid_rst), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
